adc_aperture_counter: RTL and testbench



---
 rtl/adc_aperture_counter.sv | 94 +++++++++
 tb/tb_adc_aperture_counter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adc_aperture_counter.sv
// adc_aperture_counter: counts comparator-high clocks over a triggered aperture and publishes a tagged result.
// Define ADC_CMPR_SYNC_EN to pass cmpr_i through a two-flop synchronizer.
module adc_aperture_counter #(
    parameter int CNT_W = 24,
    parameter int SEQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] p_clk_count_aperture_i,
    input  logic             adc_measure_trig_i,
    input  logic             cmpr_i,
    input  logic [2:0]       status_i,
    output logic             adc_measure_valid_o,
    output logic [CNT_W-1:0] result_o,
    output logic [2:0]       result_status_o,
    output logic [SEQ_W-1:0] seq_o
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_LO} state_t;
    state_t state_q, state_d;
    logic valid_q, valid_d;
    logic [CNT_W-1:0] remain_q, remain_d, acc_q, acc_d, result_q, result_d, acc_nxt;
    logic [2:0] stat_q, stat_d, rstat_q, rstat_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic cmpr_s;
`ifdef ADC_CMPR_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], cmpr_i};
    assign cmpr_s = sync_q[1];
`else
    assign cmpr_s = cmpr_i;
`endif
    assign acc_nxt = acc_q + CNT_W'(cmpr_s);
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        remain_d = remain_q;
        acc_d    = acc_q;
        stat_d   = stat_q;
        result_d = result_q;
        rstat_d  = rstat_q;
        seq_d    = seq_q;
        case (state_q)
            IDLE: if (adc_measure_trig_i) begin
                remain_d = (p_clk_count_aperture_i == '0) ? CNT_W'(1) : p_clk_count_aperture_i;
                stat_d   = status_i;
                acc_d    = '0;
                valid_d  = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = acc_nxt;
                remain_d = remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                    result_d = acc_nxt;
                    rstat_d  = stat_q;
                    seq_d    = seq_q + SEQ_W'(1);
                    valid_d  = !adc_measure_trig_i;
                    state_d  = adc_measure_trig_i ? WAIT_LO : IDLE;
                end
            end
            WAIT_LO: if (!adc_measure_trig_i) begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b1;
            remain_q <= '0;
            acc_q    <= '0;
            stat_q   <= '0;
            result_q <= '0;
            rstat_q  <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            remain_q <= remain_d;
            acc_q    <= acc_d;
            stat_q   <= stat_d;
            result_q <= result_d;
            rstat_q  <= rstat_d;
            seq_q    <= seq_d;
        end
    assign adc_measure_valid_o = valid_q;
    assign result_o            = result_q;
    assign result_status_o     = rstat_q;
    assign seq_o               = seq_q;
endmodule

// File: tb/tb_adc_aperture_counter.sv
// tb_adc_aperture_counter: directed table-driven checks of adc_aperture_counter (default build, no sync).
module tb_adc_aperture_counter;
    logic clk = 0, rst = 1, trig = 0, cmpr = 0;
    logic [23:0] ap = '0;
    logic [2:0] st = '0;
    logic valid;
    logic [23:0] result;
    logic [2:0] rstat;
    logic [7:0] seq;
    int n_chk = 0, n_fail = 0, mode = 0, cyc = 0, exp_seq = 0;

    adc_aperture_counter dut (
        .clk(clk), .rst(rst), .p_clk_count_aperture_i(ap), .adc_measure_trig_i(trig),
        .cmpr_i(cmpr), .status_i(st), .adc_measure_valid_o(valid), .result_o(result),
        .result_status_o(rstat), .seq_o(seq)
    );

    always #5 clk = ~clk;

    // mode 0/1: constant comparator level, mode 2: square wave of period 10
    always @(negedge clk) begin
        cyc++;
        cmpr = (mode == 2) ? ((cyc % 10) < 5) : mode[0];
    end

    typedef struct {
        int   ap;
        logic [2:0] st;
        int   mode;
        int   hold;
        bit   chg;
        int   exp_low;
        int   res_min;
        int   res_max;
        logic [2:0] exp_st;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run_meas(input vec_t v);
        int low;
        bit done;
        low = 0;
        done = 0;
        @(negedge clk);
        ap = 24'(v.ap);
        st = v.st;
        mode = v.mode;
        trig = 1;
        for (int i = 1; i <= 5000 && !done; i++) begin
            @(negedge clk);
            if (i == v.hold) trig = 0;
            if (v.chg && i == 3) begin
                ap = 24'd5;
                st = 3'b000;
            end
            if (valid) done = 1;
            else low++;
        end
        trig = 0;
        exp_seq = (exp_seq + 1) % 256;
        chk("valid_low_cycles", low, v.exp_low, v.exp_low);
        chk("result", result, v.res_min, v.res_max);
        chk("result_status", rstat, v.exp_st, v.exp_st);
        chk("seq", seq, exp_seq, exp_seq);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1000, 3'b001, 1, 1,    0, 1000, 1000, 1000, 3'b001};
        vecs[1] = '{1000, 3'b010, 2, 1,    0, 1000, 500,  500,  3'b010};
        vecs[2] = '{0,    3'b100, 2, 1,    0, 1,    0,    1,    3'b100};
        vecs[3] = '{100,  3'b011, 1, 3000, 0, 3000, 100,  100,  3'b011};
        vecs[4] = '{1000, 3'b001, 1, 1,    1, 1000, 1000, 1000, 3'b001};
        vecs[5] = '{1,    3'b111, 0, 1,    0, 1,    0,    0,    3'b111};
        vecs[6] = '{7,    3'b110, 1, 7,    0, 7,    7,    7,    3'b110};
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("reset_valid", valid, 1, 1);
            chk("reset_result", result, 0, 0);
            chk("reset_status", rstat, 0, 0);
            chk("reset_seq", seq, 0, 0);
        end
        foreach (vecs[i]) run_meas(vecs[i]);
        // abort a 1000-cycle aperture halfway with an asynchronous reset
        @(negedge clk);
        ap = 24'd1000;
        st = 3'b101;
        mode = 1;
        trig = 1;
        @(negedge clk);
        trig = 0;
        chk("midrun_valid_low", valid, 0, 0);
        repeat (500) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("abort_valid", valid, 1, 1);
        chk("abort_result", result, 0, 0);
        chk("abort_status", rstat, 0, 0);
        chk("abort_seq", seq, 0, 0);
        @(negedge clk);
        rst = 0;
        exp_seq = 0;
        run_meas(vecs[0]);
        v = '{1, 3'b010, 1, 1, 0, 1, 1, 1, 3'b010};
        for (int i = 0; i < 255; i++) run_meas(v);
        chk("seq_wrapped", seq, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
